// File: rtl/spi_rom_reader.sv
// SPI mode-0 flash burst reader: opcode + address out,
// then a stream of bytes through a one-entry valid/ready register.
`timescale 1ns/1ps

module spi_rom_reader #(
  parameter int         CLK_DIV = 2,
  parameter int         ADDR_W  = 24,
  parameter int         LEN_W   = 8,
  parameter logic [7:0] CMD     = 8'h03,
  parameter int         CS_HIGH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [7:0]        data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int SH_W = 8 + ADDR_W;
  localparam int BW   = $clog2(SH_W + 1);
  localparam int EW   = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [EW-1:0] END_LAST = EW'(CS_HIGH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_STALL, S_END
  } state_e;

  state_e state_q, state_d;

  logic [7:0]      div_q, div_d;
  logic            sclk_q, sclk_d;
  logic            cs_n_q, cs_n_d;
  logic            mosi_q, mosi_d;
  logic            done_q, done_d;
  // First opcode bit goes straight to mosi, so it is not stored here.
  logic [SH_W-2:0] tx_q, tx_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      data_q, data_d;
  logic            dv_q, dv_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] byte_q, byte_d;
  logic [EW-1:0]   end_q, end_d;

  logic shifting, active, tick, rise, fall;
  logic accept, abort_hit, cmd_end, addr_end, byte_end;
  logic can_load, load, last;

  // SCLK edge events and byte hand-off decisions
  always_comb begin
    shifting  = (state_q == S_CMD) || (state_q == S_ADDR) ||
                (state_q == S_DATA);
    active    = shifting || (state_q == S_STALL);
    tick      = shifting && (div_q == DIV_LAST);
    rise      = tick && !sclk_q;
    fall      = tick && sclk_q;
    abort_hit = abort && active;
    accept    = (state_q == S_IDLE) && start && !abort &&
                (len != '0);
    cmd_end   = fall && (state_q == S_CMD) && (bit_q == BW'(8));
    addr_end  = fall && (state_q == S_ADDR) &&
                (bit_q == BW'(SH_W));
    byte_end  = fall && (state_q == S_DATA) && (bit_q == BW'(8));
    can_load  = !dv_q || data_ready;
    load      = !abort_hit &&
                ((byte_end && can_load) ||
                 ((state_q == S_STALL) && data_ready));
    last      = load && ((byte_q + LEN_W'(1)) == len_q);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_CMD;
      S_CMD: begin
        if (abort_hit)    state_d = S_END;
        else if (cmd_end) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (abort_hit)     state_d = S_END;
        else if (addr_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (abort_hit)      state_d = S_END;
        else if (byte_end) begin
          if (!can_load)    state_d = S_STALL;
          else if (last)    state_d = S_END;
        end
      end
      S_STALL: begin
        if (abort_hit) state_d = S_END;
        else if (load) state_d = last ? S_END : S_DATA;
      end
      S_END:   if (end_q == END_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, next values
  always_comb begin
    sclk_d = sclk_q;
    cs_n_d = cs_n_q;
    mosi_d = mosi_q;
    done_d = 1'b0;
    div_d  = div_q;
    tx_d   = tx_q;
    bit_d  = bit_q;
    rx_d   = rx_q;
    data_d = data_q;
    dv_d   = dv_q;
    len_d  = len_q;
    byte_d = byte_q;
    end_d  = '0;
    if (dv_q && data_ready) dv_d = 1'b0;
    if (load) begin
      data_d = rx_q;
      dv_d   = 1'b1;
      byte_d = byte_q + LEN_W'(1);
    end
    if (last) begin
      cs_n_d = 1'b1;
      done_d = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        sclk_d = 1'b0;
        div_d  = '0;
        if (start && (len == '0)) done_d = 1'b1;
        if (accept) begin
          cs_n_d = 1'b0;
          tx_d   = {CMD[6:0], addr};
          mosi_d = CMD[7];
          len_d  = len;
          byte_d = '0;
          bit_d  = '0;
          rx_d   = '0;
        end
      end
      S_CMD, S_ADDR, S_DATA: begin
        if (tick) begin
          div_d  = '0;
          sclk_d = !sclk_q;
        end else begin
          div_d = div_q + 8'd1;
        end
        if (rise) begin
          bit_d = bit_q + BW'(1);
          if (state_q == S_DATA) rx_d = {rx_q[6:0], spi_miso};
        end
        if (fall && (state_q != S_DATA)) begin
          tx_d   = tx_q << 1;
          mosi_d = tx_q[SH_W-2];
        end
        if (addr_end) begin
          mosi_d = 1'b0;
          bit_d  = '0;
        end
        if (byte_end) bit_d = '0;
      end
      S_STALL: begin
        sclk_d = 1'b0;
        div_d  = '0;
      end
      S_END: begin
        end_d = (end_q == END_LAST) ? '0 : end_q + EW'(1);
      end
      default: ;
    endcase
    // Abort drops the partial or stalled byte; the output
    // register keeps whatever the consumer has not taken yet.
    if (abort_hit) begin
      cs_n_d = 1'b1;
      sclk_d = 1'b0;
      mosi_d = 1'b0;
      done_d = 1'b1;
      div_d  = '0;
      bit_d  = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
      cs_n_q <= 1'b1;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
      div_q  <= '0;
      tx_q   <= '0;
      bit_q  <= '0;
      rx_q   <= '0;
      data_q <= '0;
      dv_q   <= 1'b0;
      len_q  <= '0;
      byte_q <= '0;
      end_q  <= '0;
    end else begin
      sclk_q <= sclk_d;
      cs_n_q <= cs_n_d;
      mosi_q <= mosi_d;
      done_q <= done_d;
      div_q  <= div_d;
      tx_q   <= tx_d;
      bit_q  <= bit_d;
      rx_q   <= rx_d;
      data_q <= data_d;
      dv_q   <= dv_d;
      len_q  <= len_d;
      byte_q <= byte_d;
      end_q  <= end_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_spi_rom_reader.sv
// Directed bench for spi_rom_reader with a behavioural
// read-only flash on each of two instances.
`timescale 1ns/1ps

module tb_spi_rom_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, data_ready;
  logic [23:0] addr;
  logic [7:0]  len;
  logic        busy, done, data_valid;
  logic [7:0]  data;
  logic        spi_cs_n, spi_sclk, spi_mosi, spi_miso;

  logic        start1, ready1;
  logic        busy1, done1, dv1;
  logic [7:0]  data1;
  logic        cs1, sclk1, mosi1, miso1;

  int n_pass = 0;
  int n_chk  = 0;

  logic [7:0]  fmem [4];
  logic [7:0]  fmem1;
  int          rise_cnt = 0;
  int          tot_rise = 0;
  logic [31:0] mosi_sr = '0;
  int          k0, k1;
  int          rise1 = 0;
  int          done_tot = 0, cs_low_tot = 0;
  int          done1_tot = 0, cs1_low_tot = 0;
  logic [7:0]  rxq [$];

  spi_rom_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr),
    .len(len), .abort(abort), .busy(busy), .done(done),
    .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .spi_cs_n(spi_cs_n),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  spi_rom_reader #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .addr(addr),
    .len(len), .abort(abort), .busy(busy1), .done(done1),
    .data(data1), .data_valid(dv1), .data_ready(ready1),
    .spi_cs_n(cs1), .spi_sclk(sclk1), .spi_mosi(mosi1),
    .spi_miso(miso1)
  );

  // flash for dut: 32 header bits, then fmem bytes MSB first
  always @(posedge spi_sclk or posedge spi_cs_n) begin
    if (spi_cs_n) rise_cnt <= 0;
    else begin
      if (rise_cnt < 32) mosi_sr <= {mosi_sr[30:0], spi_mosi};
      rise_cnt <= rise_cnt + 1;
    end
  end

  always @(posedge spi_sclk) tot_rise <= tot_rise + 1;

  always_comb begin
    k0 = rise_cnt - 32;
    spi_miso = 1'b0;
    if (k0 >= 0 && k0 < 32)
      spi_miso = fmem[k0[4:3]][3'd7 - k0[2:0]];
  end

  // flash for dut1: one byte after the header
  always @(posedge sclk1 or posedge cs1) begin
    if (cs1) rise1 <= 0;
    else     rise1 <= rise1 + 1;
  end

  always_comb begin
    k1 = rise1 - 32;
    miso1 = 1'b0;
    if (k1 >= 0 && k1 < 8) miso1 = fmem1[3'd7 - k1[2:0]];
  end

  always @(negedge clk) begin
    if (done) done_tot <= done_tot + 1;
    if (!spi_cs_n) cs_low_tot <= cs_low_tot + 1;
    if (data_valid && data_ready) rxq.push_back(data);
    if (done1) done1_tot <= done1_tot + 1;
    if (!cs1) cs1_low_tot <= cs1_low_tot + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [23:0] a,
                             input logic [7:0] l);
    addr  = a;
    len   = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rise(input int base, input int n,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tot_rise - base >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_chk++;
    if (spi_cs_n !== 1'b1)
      $display("FAIL rst_cs_n got %b want 1", spi_cs_n);
    else n_pass++;
    n_chk++;
    if (spi_sclk !== 1'b0 || spi_mosi !== 1'b0)
      $display("FAIL rst_sclk_mosi got %b%b want 00",
               spi_sclk, spi_mosi);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_busy_done got %b%b want 00", busy, done);
    else n_pass++;
    n_chk++;
    if (data !== 8'h00 || data_valid !== 1'b0)
      $display("FAIL rst_data got %h/%b want 00/0",
               data, data_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic;
    int d0, c0, r0;
    bit ok;
    fmem[0] = 8'hA5; fmem[1] = 8'h3C;
    fmem[2] = 8'h00; fmem[3] = 8'h00;
    data_ready = 1'b1;
    rxq.delete();
    d0 = done_tot; c0 = cs_low_tot; r0 = tot_rise;
    pulse_start(24'h012345, 8'd2);
    n_chk++;
    if (busy !== 1'b1 || spi_cs_n !== 1'b0 || spi_mosi !== 1'b0)
      $display("FAIL basic_accept got %b%b%b want 100",
               busy, spi_cs_n, spi_mosi);
    else n_pass++;
    wait_done(ok);
    n_chk++;
    if (ok !== 1'b1) $display("FAIL basic_timeout got 0 want 1");
    else n_pass++;
    n_chk++;
    if (spi_cs_n !== 1'b1)
      $display("FAIL basic_cs_at_done got %b want 1", spi_cs_n);
    else n_pass++;
    tick(6);
    @(negedge clk);
    n_chk++;
    if (mosi_sr !== 32'h03012345)
      $display("FAIL basic_mosi got %h want 03012345", mosi_sr);
    else n_pass++;
    n_chk++;
    if (tot_rise - r0 !== 48)
      $display("FAIL basic_rises got %0d want 48", tot_rise - r0);
    else n_pass++;
    n_chk++;
    if (rxq.size() !== 2)
      $display("FAIL basic_nbytes got %0d want 2", rxq.size());
    else n_pass++;
    n_chk++;
    if (rxq.size() < 2 || rxq[0] !== 8'hA5 || rxq[1] !== 8'h3C)
      $display("FAIL basic_bytes got size %0d want A5 3C",
               rxq.size());
    else n_pass++;
    n_chk++;
    if (done_tot - d0 !== 1)
      $display("FAIL basic_done_cnt got %0d want 1", done_tot - d0);
    else n_pass++;
    n_chk++;
    if (cs_low_tot - c0 !== 192)
      $display("FAIL basic_cs_low got %0d want 192",
               cs_low_tot - c0);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0 || data_valid !== 1'b0)
      $display("FAIL basic_idle got %b%b want 00", busy, data_valid);
    else n_pass++;
    tick(1);
  endtask

  task automatic test_len0;
    int d0, c0;
    d0 = done_tot; c0 = cs_low_tot;
    pulse_start(24'hABCDEF, 8'd0);
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL len0_done got %b/%b want 1/0", done, busy);
    else n_pass++;
    tick(4);
    @(negedge clk);
    n_chk++;
    if (cs_low_tot - c0 !== 0 || done_tot - d0 !== 1)
      $display("FAIL len0_cs got cs %0d done %0d want 0 1",
               cs_low_tot - c0, done_tot - d0);
    else n_pass++;
    tick(1);
  endtask

  task automatic test_busy_start;
    int d0;
    bit ok;
    fmem[0] = 8'h66;
    data_ready = 1'b1;
    rxq.delete();
    d0 = done_tot;
    pulse_start(24'h00A0B0, 8'd1);
    tick(10);
    pulse_start(24'hFFFFFF, 8'd3);
    wait_done(ok);
    n_chk++;
    if (ok !== 1'b1) $display("FAIL busy_timeout got 0 want 1");
    else n_pass++;
    tick(6);
    @(negedge clk);
    n_chk++;
    if (mosi_sr !== 32'h0300A0B0)
      $display("FAIL busy_addr got %h want 0300A0B0", mosi_sr);
    else n_pass++;
    n_chk++;
    if (rxq.size() !== 1 || rxq[0] !== 8'h66 ||
        done_tot - d0 !== 1 || busy !== 1'b0)
      $display("FAIL busy_ignore got n %0d done %0d want 1 1",
               rxq.size(), done_tot - d0);
    else n_pass++;
    tick(1);
  endtask

  task automatic test_abort;
    int r0, b;
    bit ok;
    data_ready = 1'b1;
    rxq.delete();
    r0 = tot_rise;
    pulse_start(24'h123456, 8'd2);
    wait_rise(r0, 18, ok);
    n_chk++;
    if (ok !== 1'b1) $display("FAIL abort_wait got 0 want 1");
    else n_pass++;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    n_chk++;
    if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || done !== 1'b1)
      $display("FAIL abort_resp got cs%b sclk%b done%b want 101",
               spi_cs_n, spi_sclk, done);
    else n_pass++;
    b = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) b++;
      @(negedge clk);
    end
    n_chk++;
    if (b !== 2) $display("FAIL abort_end_len got %0d want 2", b);
    else n_pass++;
    n_chk++;
    if (rxq.size() !== 0 || data_valid !== 1'b0)
      $display("FAIL abort_nodata got %0d/%b want 0/0",
               rxq.size(), data_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_idle got %b%b want 00", done, busy);
    else n_pass++;
    fmem[0] = 8'hC3;
    @(posedge clk);
    #1;
    pulse_start(24'h000010, 8'd1);
    wait_done(ok);
    tick(4);
    @(negedge clk);
    n_chk++;
    if (ok !== 1'b1 || mosi_sr !== 32'h03000010 ||
        rxq.size() !== 1 || rxq[0] !== 8'hC3)
      $display("FAIL abort_restart got %h n %0d want 03000010 1",
               mosi_sr, rxq.size());
    else n_pass++;
    tick(1);
  endtask

  task automatic test_stall;
    int d0, r1, hi, csh, bad;
    bit ok;
    fmem[0] = 8'h11; fmem[1] = 8'h22; fmem[2] = 8'h33;
    data_ready = 1'b0;
    rxq.delete();
    d0 = done_tot;
    pulse_start(24'h000100, 8'd3);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (data_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (ok !== 1'b1 || data !== 8'h11)
      $display("FAIL stall_first got %b/%h want 1/11", ok, data);
    else n_pass++;
    r1 = tot_rise;
    wait_rise(r1, 8, ok);
    repeat (12) @(negedge clk);
    hi = 0; csh = 0; bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (spi_sclk) hi++;
      if (spi_cs_n) csh++;
      if (!data_valid || data !== 8'h11) bad++;
    end
    n_chk++;
    if (hi !== 0 || csh !== 0)
      $display("FAIL stall_bus got sclk %0d cs %0d want 0 0",
               hi, csh);
    else n_pass++;
    n_chk++;
    if (tot_rise - r1 !== 8 || bad !== 0 || !ok)
      $display("FAIL stall_hold got rises %0d bad %0d want 8 0",
               tot_rise - r1, bad);
    else n_pass++;
    @(posedge clk);
    #1;
    data_ready = 1'b1;
    wait_done(ok);
    tick(4);
    @(negedge clk);
    n_chk++;
    if (!ok || rxq.size() !== 3)
      $display("FAIL stall_count got %0d want 3", rxq.size());
    else n_pass++;
    n_chk++;
    if (rxq.size() < 3 || rxq[0] !== 8'h11 ||
        rxq[1] !== 8'h22 || rxq[2] !== 8'h33)
      $display("FAIL stall_order got size %0d want 11 22 33",
               rxq.size());
    else n_pass++;
    n_chk++;
    if (done_tot - d0 !== 1)
      $display("FAIL stall_done got %0d want 1", done_tot - d0);
    else n_pass++;
    tick(1);
  endtask

  task automatic test_rst_mid;
    int d0, r0;
    bit ok;
    fmem[0] = 8'h77; fmem[1] = 8'h88;
    data_ready = 1'b1;
    d0 = done_tot; r0 = tot_rise;
    pulse_start(24'h000000, 8'd2);
    wait_rise(r0, 36, ok);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (!ok || spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 ||
        spi_mosi !== 1'b0)
      $display("FAIL rstmid_spi got %b%b%b want 100",
               spi_cs_n, spi_sclk, spi_mosi);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || data_valid !== 1'b0 ||
        data !== 8'h00)
      $display("FAIL rstmid_out got %b%b%b %h want 000 00",
               busy, done, data_valid, data);
    else n_pass++;
    tick(4);
    rst_n = 1'b1;
    tick(5);
    @(negedge clk);
    n_chk++;
    if (done_tot - d0 !== 0 || busy !== 1'b0)
      $display("FAIL rstmid_nodone got %0d/%b want 0/0",
               done_tot - d0, busy);
    else n_pass++;
    tick(1);
  endtask

  task automatic test_div1;
    int d1, c1, lost;
    bit ok;
    fmem1  = 8'h5A;
    ready1 = 1'b0;
    d1 = done1_tot; c1 = cs1_low_tot;
    addr   = 24'h000200;
    len    = 8'd1;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done1) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok || dv1 !== 1'b1 || data1 !== 8'h5A || cs1 !== 1'b1)
      $display("FAIL div1_done got %b%b %h %b want 11 5A 1",
               ok, dv1, data1, cs1);
    else n_pass++;
    lost = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!dv1 || data1 !== 8'h5A) lost++;
    end
    n_chk++;
    if (lost !== 0)
      $display("FAIL div1_hold got %0d want 0", lost);
    else n_pass++;
    n_chk++;
    if (cs1_low_tot - c1 !== 80 || done1_tot - d1 !== 1)
      $display("FAIL div1_cs got %0d/%0d want 80/1",
               cs1_low_tot - c1, done1_tot - d1);
    else n_pass++;
    @(posedge clk);
    #1;
    ready1 = 1'b1;
    @(posedge clk);
    #1;
    ready1 = 1'b0;
    @(negedge clk);
    n_chk++;
    if (dv1 !== 1'b0)
      $display("FAIL div1_clear got %b want 0", dv1);
    else n_pass++;
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; data_ready = 1'b1;
    addr = '0; len = '0;
    start1 = 1'b0; ready1 = 1'b0; fmem1 = '0;
    for (int i = 0; i < 4; i++) fmem[i] = '0;
    test_reset();
    test_basic();
    test_len0();
    test_busy_start();
    test_abort();
    test_stall();
    test_rst_mid();
    test_div1();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_rom_reader.md
SPI_ROM_READER -- requirements
Module: spi_rom_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period, legal values 1..255.
REQ-002 SHALL have parameter ADDR_W, default 24, meaning flash address bits sent after the command, multiple of 8.
REQ-003 SHALL have parameter LEN_W, default 8, meaning width of the burst-length input.
REQ-004 SHALL have parameter CMD, default 8'h03, meaning read opcode sent MSB first.
REQ-005 SHALL have parameter CS_HIGH, default 2, meaning minimum clk cycles spi_cs_n stays high between transactions, legal values >=1.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1 bit: request a burst; sampled only in IDLE.
REQ-009 SHALL have port addr, input, ADDR_W bits: start address, captured with start.
REQ-010 SHALL have port len, input, LEN_W bits: byte count, captured with start.
REQ-011 SHALL have port abort, input, 1 bit: terminate the current burst.
REQ-012 SHALL have port busy, output, 1 bit: high from the cycle after accepted start until the END state exits.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at burst completion or abort.
REQ-014 SHALL have port data, output, 8 bits: received byte.
REQ-015 SHALL have port data_valid, output, 1 bit: data holds an unconsumed byte.
REQ-016 SHALL have port data_ready, input, 1 bit: consumer accepts data when data_valid && data_ready.
REQ-017 SHALL have ports spi_cs_n, spi_sclk, spi_mosi (outputs, 1 bit) and spi_miso (input, 1 bit), all SPI mode 0.

Function
REQ-018 SHALL implement states IDLE, CMD, ADDR, DATA, STALL, END.
REQ-019 IDLE: start=1, abort=0, len!=0 SHALL capture addr/len; spi_cs_n falls next cycle, CMD entered, spi_mosi=CMD[7].
REQ-020 IDLE: start=1 with len=0 SHALL assert done next cycle and remain IDLE; spi_cs_n stays high.
REQ-021 SHALL keep SCLK idle low; first rising edge occurs CLK_DIV cycles after spi_cs_n falls; each half-period lasts CLK_DIV cycles.
REQ-022 SHALL change spi_mosi only on SCLK falling edges (or at CS fall for the first bit), and sample spi_miso on SCLK rising edges.
REQ-023 CMD SHALL shift 8 bits, then ADDR SHALL shift ADDR_W bits MSB first; spi_mosi is 0 during DATA.
REQ-024 DATA SHALL assemble bytes MSB first; after the 8th rising edge, at the following falling edge, the byte loads into data and data_valid sets if data_valid=0 or data_ready=1 that cycle.
REQ-025 If the register is occupied and data_ready=0, SHALL enter STALL: SCLK held low, CS held low, byte held in the shift register; it loads on the first cycle data_ready=1, then DATA resumes after a full half-period.
REQ-026 data_valid SHALL clear on the cycle after handshake unless a new byte loads that same cycle.
REQ-027 After the len-th byte loads, SHALL raise spi_cs_n the next cycle, pulse done in that same cycle, enter END.
REQ-028 END SHALL hold spi_cs_n high for CS_HIGH cycles, then return to IDLE; busy drops on entry to IDLE.
REQ-029 abort while busy in CMD/ADDR/DATA/STALL SHALL raise spi_cs_n, force SCLK low next cycle, pulse done, discard any partial or stalled byte, enter END; data/data_valid unchanged.
REQ-030 abort in IDLE or END SHALL be ignored; start while busy SHALL be ignored.
REQ-031 A byte counter of LEN_W bits SHALL count loaded bytes; no wrap, burst ends at len.

Reset
REQ-032 rst_n low SHALL immediately force spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, data=8'h00, data_valid=0, state IDLE, counters 0.
REQ-033 Reset mid-burst SHALL behave identically to REQ-032; no done pulse is produced.

Verification
REQ-034 Defaults, addr=24'h012345, len=2, data_ready=1, flash model returns 8'hA5, 8'h3C -> MOSI stream 03 01 23 45, 32 SCLK rising edges before data, two data_valid pulses A5 then 3C, done once, CS low for exactly 48 SCLK periods.
REQ-035 CLK_DIV=1, len=1, data_ready=0 for 40 cycles after first byte -> no stall needed, data=byte held valid, CS rises, done pulse; data_valid stays 1 until handshake.
REQ-036 len=3, data_ready=0 after first byte -> STALL: SCLK low, CS low for the whole stall; release -> bytes 2,3 delivered in order, none lost.
REQ-037 abort asserted mid-ADDR (bit 10) -> next cycle CS high, SCLK low, done=1, no data_valid; END lasts CS_HIGH cycles; new start then accepted.
REQ-038 start with len=0 -> done next cycle, CS never low; start while busy -> ignored, captured addr unchanged.
REQ-039 rst_n low during DATA -> all outputs at reset values within the same cycle, no done pulse.
